// File: rtl/psu_pkg.sv
// Shared types and defaults for the PSU rail soft-start drivers.
// Rail FSM states and the default PWM/ramp/power-good geometry live here so
// every rail instance and its helpers agree on them.
package psu_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        RAMP  = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } rail_state_t;

    localparam int PSU_PWM_CNT_W  = 8;
    localparam int PSU_RAMP_DIV   = 16;
    localparam int PSU_DUTY_MAX   = 200;
    localparam int PSU_PG_TIMEOUT = 1000;

    // A rail is "running" (switch allowed to toggle) only in RAMP or HOLD.
    function automatic logic is_running(input rail_state_t s);
        return (s == RAMP) || (s == HOLD);
    endfunction

endpackage

// File: rtl/pg_monitor.sv
// Power-good loss detector for one rail.
// pg_in is asynchronous, so it is brought into the clk domain with two flops.
// While hold is high, a saturating counter counts consecutive clocks of
// synchronised pg low; any pg high (or leaving HOLD) clears it. pg_lost is
// raised once the count reaches PG_TIMEOUT.
module pg_monitor
    import psu_pkg::*;
#(
    parameter int PG_TIMEOUT = PSU_PG_TIMEOUT
) (
    input  logic clk,
    input  logic n_rst,
    input  logic pg_in,
    input  logic hold,
    output logic pg_lost
);

    localparam int PGC_W = $clog2(PG_TIMEOUT + 1);
    localparam logic [PGC_W-1:0] PG_LIMIT = PGC_W'(PG_TIMEOUT);

    logic             pg_meta;
    logic             pg_sync;
    logic [PGC_W-1:0] pg_cnt;

    // Two-flop synchroniser for the asynchronous comparator output.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pg_meta <= 1'b0;
            pg_sync <= 1'b0;
        end else begin
            pg_meta <= pg_in;
            pg_sync <= pg_meta;
        end
    end

    // Consecutive-low counter, only meaningful in HOLD; saturates at the limit.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pg_cnt <= '0;
        end else if (!hold || pg_sync) begin
            pg_cnt <= '0;
        end else if (pg_cnt != PG_LIMIT) begin
            pg_cnt <= pg_cnt + PGC_W'(1);
        end
    end

    assign pg_lost = hold && (pg_cnt == PG_LIMIT);

endmodule

// File: rtl/rail_softstart_pwm.sv
// Per-rail soft-start PWM driver.
// On en the rail ramps its switch duty from 0 up to a latched target, one
// count every RAMP_DIV PWM periods, then holds and reports ramp_done.
// Duty only changes at the PWM period boundary so no runt pulses occur.
// Optional build macro PG_TIMEOUT_EN: adds pg_monitor and the HOLD->FAULT
// trip on sustained loss of power-good; without it pg_in is ignored and
// fault is constant 0.
module rail_softstart_pwm
    import psu_pkg::*;
#(
    parameter int CNT_W      = PSU_PWM_CNT_W,
    parameter int DUTY_MAX   = PSU_DUTY_MAX,
    parameter int RAMP_DIV   = PSU_RAMP_DIV,
    parameter int PG_TIMEOUT = PSU_PG_TIMEOUT
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             en,
    input  logic             pg_in,
    input  logic [CNT_W-1:0] duty_tgt,
    output logic             pwm_out,
    output logic             busy,
    output logic             ramp_done,
    output logic             fault
);

    localparam int DMAX_I = (DUTY_MAX > (2**CNT_W) - 1) ? (2**CNT_W) - 1 : DUTY_MAX;
    localparam logic [CNT_W-1:0] DMAX = CNT_W'(DMAX_I);
    localparam int STEP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(RAMP_DIV - 1);

    rail_state_t       state;
    rail_state_t       state_nxt;
    logic [CNT_W-1:0]  pwm_cnt;
    logic [CNT_W-1:0]  duty;
    logic [CNT_W-1:0]  tgt_l;
    logic [CNT_W-1:0]  tgt_clamped;
    logic [STEP_W-1:0] step_cnt;
    logic              period_end;
    logic              step_end;
    logic              pg_lost;

    assign tgt_clamped = (duty_tgt > DMAX) ? DMAX : duty_tgt;
    assign period_end  = (pwm_cnt == '1);
    assign step_end    = period_end && (step_cnt == STEP_LAST);

`ifdef PG_TIMEOUT_EN
    pg_monitor #(
        .PG_TIMEOUT (PG_TIMEOUT)
    ) u_pg_monitor (
        .clk     (clk),
        .n_rst   (n_rst),
        .pg_in   (pg_in),
        .hold    (state == HOLD),
        .pg_lost (pg_lost)
    );
    assign fault = (state == FAULT);
`else
    logic unused_pg;
    assign unused_pg = pg_in;
    assign pg_lost   = 1'b0;
    assign fault     = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= OFF;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: en low always wins; FAULT is left only through en low.
    always_comb begin
        state_nxt = state;
        case (state)
            OFF: begin
                if (en) state_nxt = RAMP;
            end
            RAMP: begin
                if (!en) begin
                    state_nxt = OFF;
                end else if (step_end &&
                             ((duty >= tgt_l) || ((duty + CNT_W'(1)) == tgt_l))) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (!en) begin
                    state_nxt = OFF;
                end else if (pg_lost) begin
                    state_nxt = FAULT;
                end
            end
            FAULT: begin
                if (!en) state_nxt = OFF;
            end
            default: state_nxt = OFF;
        endcase
    end

    // PWM counter, step counter, duty ramp, target latch and registered drive.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pwm_cnt  <= '0;
            duty     <= '0;
            tgt_l    <= '0;
            step_cnt <= '0;
            pwm_out  <= 1'b0;
        end else begin
            // Drive is dropped on the same edge the rail leaves RAMP/HOLD.
            pwm_out <= is_running(state) && is_running(state_nxt) && (pwm_cnt < duty);
            if (state == OFF) begin
                pwm_cnt  <= '0;
                duty     <= '0;
                step_cnt <= '0;
                if (en) tgt_l <= tgt_clamped;
            end else if (!is_running(state_nxt)) begin
                pwm_cnt  <= '0;
                duty     <= '0;
                step_cnt <= '0;
            end else begin
                pwm_cnt <= pwm_cnt + CNT_W'(1);
                if (period_end) begin
                    step_cnt <= (step_cnt == STEP_LAST) ? '0 : step_cnt + STEP_W'(1);
                end
                if ((state == RAMP) && step_end && (duty < tgt_l)) begin
                    duty <= duty + CNT_W'(1);
                end
            end
        end
    end

    assign busy      = is_running(state);
    assign ramp_done = (state == HOLD);

endmodule

// File: tb/tb_rail_softstart_pwm.sv
// Directed bench for rail_softstart_pwm with CNT_W=4, DUTY_MAX=12,
// RAMP_DIV=2, PG_TIMEOUT=20. Expected values are pushed to exp_q as each
// stimulus step is applied and popped when the DUT output is sampled.
// Status vector packing: {busy, ramp_done, fault, pwm_out}.
module tb_rail_softstart_pwm;

    localparam int CNT_W      = 4;
    localparam int DUTY_MAX   = 12;
    localparam int RAMP_DIV   = 2;
    localparam int PG_TIMEOUT = 20;
    localparam int W          = 16;

    logic             clk;
    logic             n_rst;
    logic             en;
    logic             pg_in;
    logic [CNT_W-1:0] duty_tgt;
    logic             pwm_out;
    logic             busy;
    logic             ramp_done;
    logic             fault;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];

    rail_softstart_pwm #(
        .CNT_W      (CNT_W),
        .DUTY_MAX   (DUTY_MAX),
        .RAMP_DIV   (RAMP_DIV),
        .PG_TIMEOUT (PG_TIMEOUT)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .en        (en),
        .pg_in     (pg_in),
        .duty_tgt  (duty_tgt),
        .pwm_out   (pwm_out),
        .busy      (busy),
        .ramp_done (ramp_done),
        .fault     (fault)
    );

    // Clock: 10 ns period, DUT active on posedge, bench samples on negedge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] status();
        return {12'd0, busy, ramp_done, fault, pwm_out};
    endfunction

    task automatic push_exp(input logic [W-1:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs);
        logic [W-1:0] exp_v;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: observed %0d, no expected value queued", tag, obs);
        end else begin
            exp_v = exp_q.pop_front();
            assert (obs === exp_v) else begin
                errors++;
                $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Clocks until ramp_done rises (bounded) and pwm_out highs seen meanwhile.
    task automatic wait_done(output int t, output int highs);
        t = 0;
        highs = 0;
        while (!ramp_done && t < 2000) begin
            step(1);
            t++;
            if (pwm_out) highs++;
        end
    endtask

    task automatic count_highs(input int n, output int h);
        h = 0;
        for (int i = 0; i < n; i++) begin
            step(1);
            if (pwm_out) h++;
        end
    endtask

    task automatic start_rail(input logic [CNT_W-1:0] tgt, input string tag);
        duty_tgt = tgt;
        en = 1'b1;
        push_exp(W'(4'b1000));
        step(1);
        check(tag, status());
    endtask

    task automatic stop_rail(input string tag);
        en = 1'b0;
        push_exp(W'(4'b0000));
        step(1);
        check(tag, status());
    endtask

    initial begin
        int t;
        int h;

        // Reset held low with en high: everything stays quiet.
        n_rst = 1'b0;
        en = 1'b1;
        pg_in = 1'b1;
        duty_tgt = 4'd4;
        push_exp(W'(0));
        step(1);
        check("reset_outputs", status());
        push_exp(W'(0));
        step(5);
        check("reset_hold", status());
        en = 1'b0;
        n_rst = 1'b1;
        step(2);

        // Target 4: HOLD after 4 steps * 2 periods * 16 clocks.
        start_rail(4'd4, "t4_busy");
        push_exp(W'(128));
        push_exp(W'(12));
        wait_done(t, h);
        check("t4_done_time", W'(t));
        check("t4_ramp_highs", W'(h));
        push_exp(W'(4));
        count_highs(16, h);
        check("t4_hold_duty", W'(h));
        // Target changes after the latch must not matter.
        duty_tgt = 4'd9;
        push_exp(W'(4));
        count_highs(32, h);
        check("t4_tgt_ignored", W'(h / 2));
        stop_rail("t4_off");

        // Target 15 clamps to 12.
        start_rail(4'd15, "t15_busy");
        push_exp(W'(384));
        wait_done(t, h);
        check("t15_done_time", W'(t));
        push_exp(W'(12));
        count_highs(16, h);
        check("t15_hold_duty", W'(h));
        stop_rail("t15_off");

        // en dropped mid-ramp while the switch is on, then re-raised.
        start_rail(4'd4, "abort_busy");
        push_exp(W'(4'b1001));
        step(65);
        check("abort_pwm_on", status());
        stop_rail("abort_off");
        start_rail(4'd4, "restart_busy");
        push_exp(W'(128));
        push_exp(W'(12));
        wait_done(t, h);
        check("restart_done_time", W'(t));
        check("restart_ramp_highs", W'(h));
        stop_rail("restart_off");

        // Target 0: HOLD at the first step boundary, switch never on.
        start_rail(4'd0, "t0_busy");
        push_exp(W'(32));
        push_exp(W'(0));
        wait_done(t, h);
        check("t0_done_time", W'(t));
        check("t0_ramp_highs", W'(h));
        push_exp(W'(0));
        count_highs(32, h);
        check("t0_hold_highs", W'(h));
        stop_rail("t0_off");

        // Power-good handling in HOLD.
        start_rail(4'd4, "pg_busy");
        push_exp(W'(128));
        wait_done(t, h);
        check("pg_done_time", W'(t));
`ifdef PG_TIMEOUT_EN
        pg_in = 1'b0;
        push_exp(W'(0));
        step(21);
        check("pg_not_yet", W'(fault));
        push_exp(W'(4'b0010));
        step(2);
        check("pg_fault", status());
        push_exp(W'(0));
        count_highs(16, h);
        check("pg_fault_quiet", W'(h));
        push_exp(W'(4'b0010));
        check("pg_fault_sticky", status());
        pg_in = 1'b1;
        stop_rail("pg_fault_clear");
        start_rail(4'd4, "pgp_busy");
        push_exp(W'(128));
        wait_done(t, h);
        check("pgp_done_time", W'(t));
        pg_in = 1'b0;
        step(10);
        pg_in = 1'b1;
        step(1);
        pg_in = 1'b0;
        push_exp(W'(4'b1100));
        step(21);
        check("pgp_restarted", {12'd0, busy, ramp_done, fault, 1'b0});
        push_exp(W'(4'b0010));
        step(2);
        check("pgp_fault", status());
        pg_in = 1'b1;
        stop_rail("pgp_clear");
`else
        pg_in = 1'b0;
        push_exp(W'(4'b1100));
        step(40);
        check("pg_ignored", {12'd0, busy, ramp_done, fault, 1'b0});
        pg_in = 1'b1;
        stop_rail("pg_off");
`endif

        // Asynchronous reset mid-ramp drops the drive without a clock edge.
        start_rail(4'd4, "areset_busy");
        push_exp(W'(4'b1001));
        step(65);
        check("areset_pwm_on", status());
        #2 n_rst = 1'b0;
        push_exp(W'(0));
        #1 check("areset_async", status());
        @(negedge clk);
        en = 1'b0;
        n_rst = 1'b1;
        push_exp(W'(0));
        step(2);
        check("areset_after", status());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
